// File: rtl/adc_req_arbiter.sv
`default_nettype none
// ============================================================================
// adc_req_arbiter : four-way conversion request arbiter in front of a SAR ADC
// Optional watchdog compiled in with ADC_ARB_TIMEOUT_EN.  Rev 1.0
// ============================================================================
module adc_req_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 12,
  parameter int TMO_W = 16,
  parameter int GAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              prio_mode,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] req_ch,
  output logic [NREQ-1:0]   gnt,
  output logic              adc_soc,
  output logic [2:0]        adc_ch_sel,
  input  logic              adc_eoc,
  input  logic [DW-1:0]     adc_data,
  input  logic [GAP_W-1:0]  gap_cyc,
  input  logic [TMO_W-1:0]  tmo_limit,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_id,
  output logic [2:0]        rsp_ch,
  output logic [DW-1:0]     rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              timeout_irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t           state;
  logic [1:0]       last_id;
  logic             eoc_q;
  logic [GAP_W-1:0] gap_cnt;

  logic [1:0]       win_id;
  logic             win_found;
  logic [2:0]       win_ch;
  logic [1:0]       rr_idx;
  logic             eoc_rise;

  // A level that was already high before CONV is not a completion.
  assign eoc_rise = adc_eoc & ~eoc_q;

  always_comb begin
    win_id    = 2'd0;
    win_found = 1'b0;
    win_ch    = 3'd0;
    rr_idx    = 2'd0;
    if (prio_mode) begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (req[i]) begin
          win_id    = 2'(i);
          win_found = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        rr_idx = last_id + 2'(i + 1);
        if (!win_found && req[rr_idx]) begin
          win_id    = rr_idx;
          win_found = 1'b1;
        end
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (2'(i) == win_id) win_ch = req_ch[3*i +: 3];
    end
  end

`ifdef ADC_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             err_q;
  logic             irq_q;

  // Fires on the CONV cycle that would make the count reach the limit.
  assign tmo_hit     = (tmo_limit != '0) && ((tmo_cnt + TMO_W'(1)) == tmo_limit);
  assign rsp_err     = err_q;
  assign timeout_irq = irq_q;
`else
  logic unused_tmo;
  assign unused_tmo  = ^tmo_limit;
  assign rsp_err     = 1'b0;
  assign timeout_irq = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_id    <= 2'd3;
      eoc_q      <= 1'b0;
      gap_cnt    <= '0;
      gnt        <= '0;
      adc_soc    <= 1'b0;
      adc_ch_sel <= 3'd0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 2'd0;
      rsp_ch     <= 3'd0;
      rsp_data   <= '0;
      busy       <= 1'b0;
`ifdef ADC_ARB_TIMEOUT_EN
      tmo_cnt    <= '0;
      err_q      <= 1'b0;
      irq_q      <= 1'b0;
`endif
    end else begin
      eoc_q <= adc_eoc;
      gnt   <= '0;
`ifdef ADC_ARB_TIMEOUT_EN
      irq_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (en && win_found) begin
            state      <= CONV;
            gnt        <= NREQ'(1) << win_id;
            adc_soc    <= 1'b1;
            busy       <= 1'b1;
            last_id    <= win_id;
            rsp_id     <= win_id;
            rsp_ch     <= win_ch;
            adc_ch_sel <= win_ch;
`ifdef ADC_ARB_TIMEOUT_EN
            tmo_cnt    <= '0;
            err_q      <= 1'b0;
`endif
          end
        end
        CONV: begin
          if (eoc_rise) begin
            rsp_data  <= adc_data;
            rsp_valid <= 1'b1;
            adc_soc   <= 1'b0;
            state     <= RESP;
          end
`ifdef ADC_ARB_TIMEOUT_EN
          else if (tmo_hit) begin
            rsp_data  <= '0;
            rsp_valid <= 1'b1;
            adc_soc   <= 1'b0;
            err_q     <= 1'b1;
            irq_q     <= 1'b1;
            state     <= RESP;
          end else begin
            tmo_cnt   <= tmo_cnt + TMO_W'(1);
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            gap_cnt   <= '0;
            state     <= GAP;
          end
        end
        GAP: begin
          // Keeps soc low long enough for the core's slow-clock edge detector.
          if (gap_cnt >= gap_cyc) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_req_arbiter.sv
`default_nettype none
// tb_adc_req_arbiter : directed self-checking bench for adc_req_arbiter.
module tb_adc_req_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        prio_mode;
  logic [3:0]  req;
  logic [11:0] req_ch;
  logic [3:0]  gnt;
  logic        adc_soc;
  logic [2:0]  adc_ch_sel;
  logic        adc_eoc;
  logic [11:0] adc_data;
  logic [7:0]  gap_cyc;
  logic [15:0] tmo_limit;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [2:0]  rsp_ch;
  logic [11:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        timeout_irq;

  logic [28:0] all_out;
  assign all_out = {gnt, adc_soc, adc_ch_sel, rsp_valid, rsp_id, rsp_ch,
                    rsp_data, rsp_err, busy, timeout_irq};

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  adc_req_arbiter dut (
    .clk(clk), .rst(rst), .en(en), .prio_mode(prio_mode), .req(req),
    .req_ch(req_ch), .gnt(gnt), .adc_soc(adc_soc), .adc_ch_sel(adc_ch_sel),
    .adc_eoc(adc_eoc), .adc_data(adc_data), .gap_cyc(gap_cyc),
    .tmo_limit(tmo_limit), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_ch(rsp_ch), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .timeout_irq(timeout_irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; en = 1'b1; prio_mode = 1'b0; req = 4'b0; req_ch = 12'h0;
    adc_eoc = 1'b0; adc_data = 12'h0; gap_cyc = 8'd0; tmo_limit = 16'd0;
    rsp_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_gnt(output logic [3:0] g, output bit ok);
    g = 4'b0; ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (|gnt) begin g = gnt; ok = 1'b1; end
    end
  endtask

  // One full conversion with immediate acceptance; returns the grant seen.
  task automatic run_conv(output logic [3:0] g);
    bit ok;
    wait_gnt(g, ok);
    if (ok) begin
      tick(); tick();
      adc_eoc = 1'b1;
      tick();
      adc_eoc = 1'b0; rsp_ready = 1'b1;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; prio_mode = 1'b0; req = 4'b1111; req_ch = 12'hFFF;
    adc_eoc = 1'b0; adc_data = 12'hFFF; gap_cyc = 8'd0; tmo_limit = 16'd0;
    rsp_ready = 1'b1;
    tick(); tick();
    n_cmp++;
    if (all_out !== 29'd0) begin
      n_bad++; $display("FAIL reset_outputs: got %h expected %h", all_out, 29'd0);
    end
    req = 4'b0;
    rst = 1'b0;
    tick();
    n_cmp++;
    if (all_out !== 29'd0) begin
      n_bad++; $display("FAIL idle_after_reset: got %h expected %h", all_out, 29'd0);
    end
  endtask

  task automatic test_single();
    apply_reset();
    req_ch = 12'h0; req_ch[8:6] = 3'd5; adc_data = 12'hA5C; req = 4'b0100;
    tick();
    n_cmp++;
    if ({gnt, adc_soc, adc_ch_sel, busy} !== {4'b0100, 1'b1, 3'd5, 1'b1}) begin
      n_bad++; $display("FAIL single_grant: got gnt=%b soc=%b ch=%0d busy=%b expected gnt=0100 soc=1 ch=5 busy=1",
                        gnt, adc_soc, adc_ch_sel, busy);
    end
    req = 4'b0;
    tick(); tick(); tick();
    n_cmp++;
    if ({gnt, adc_soc, rsp_valid} !== {4'b0000, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL single_conv_wait: got gnt=%b soc=%b valid=%b expected 0000 1 0",
                        gnt, adc_soc, rsp_valid);
    end
    adc_eoc = 1'b1;
    tick();
    n_cmp++;
    if ({rsp_valid, adc_soc, rsp_id, rsp_ch, rsp_data, rsp_err} !==
        {1'b1, 1'b0, 2'd2, 3'd5, 12'hA5C, 1'b0}) begin
      n_bad++; $display("FAIL single_resp: got v=%b soc=%b id=%0d ch=%0d data=%h err=%b expected 1 0 2 5 a5c 0",
                        rsp_valid, adc_soc, rsp_id, rsp_ch, rsp_data, rsp_err);
    end
    adc_eoc = 1'b0;
    tick();
    n_cmp++;
    if ({rsp_valid, busy} !== 2'b01) begin
      n_bad++; $display("FAIL single_handshake: got valid=%b busy=%b expected 0 1", rsp_valid, busy);
    end
    tick();
    n_cmp++;
    if ({busy, adc_ch_sel} !== {1'b0, 3'd5}) begin
      n_bad++; $display("FAIL single_back_idle: got busy=%b ch_sel=%0d expected 0 5", busy, adc_ch_sel);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] g;
    logic [3:0] exp_rr [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    apply_reset();
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      run_conv(g);
      n_cmp++;
      if (g !== exp_rr[k]) begin
        n_bad++; $display("FAIL rr_order[%0d]: got %b expected %b", k, g, exp_rr[k]);
      end
    end
    prio_mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      run_conv(g);
      n_cmp++;
      if (g !== 4'b0001) begin
        n_bad++; $display("FAIL fixed_order[%0d]: got %b expected 0001", k, g);
      end
    end
    req = 4'b0; prio_mode = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [3:0] g;
    bit ok;
    apply_reset();
    req_ch[5:3] = 3'd3; req = 4'b0010; rsp_ready = 1'b0;
    wait_gnt(g, ok);
    n_cmp++;
    if (g !== 4'b0010) begin
      n_bad++; $display("FAIL bp_grant: got %b expected 0010", g);
    end
    tick(); tick();
    adc_data = 12'h123; adc_eoc = 1'b1;
    tick();
    adc_data = 12'hFFF; adc_eoc = 1'b0;
    for (int k = 0; k < 10; k++) begin
      n_cmp++;
      if ({rsp_valid, rsp_data, gnt, adc_soc} !== {1'b1, 12'h123, 4'b0, 1'b0}) begin
        n_bad++; $display("FAIL bp_hold[%0d]: got v=%b data=%h gnt=%b soc=%b expected 1 123 0000 0",
                          k, rsp_valid, rsp_data, gnt, adc_soc);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL bp_release: got valid=%b expected 0", rsp_valid);
    end
    req = 4'b0;
  endtask

  task automatic test_gap_stale();
    logic [3:0] g;
    int  n;
    bit  soc_seen;
    apply_reset();
    gap_cyc = 8'd6; req = 4'b0001;
    run_conv(g);
    adc_eoc = 1'b1;
    n = 0; soc_seen = 1'b0; g = 4'b0;
    for (int i = 0; i < 30 && g == 4'b0; i++) begin
      if (adc_soc) soc_seen = 1'b1;
      tick();
      n++;
      g = gnt;
    end
    n_cmp++;
    if (n !== 8 || soc_seen) begin
      n_bad++; $display("FAIL gap_length: got %0d cycles soc_seen=%b expected 8 cycles soc_seen=0", n, soc_seen);
    end
    req = 4'b0;
    repeat (5) tick();
    n_cmp++;
    if ({rsp_valid, adc_soc} !== 2'b01) begin
      n_bad++; $display("FAIL stale_eoc_high: got valid=%b soc=%b expected 0 1", rsp_valid, adc_soc);
    end
    adc_eoc = 1'b0;
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL stale_eoc_low: got valid=%b expected 0", rsp_valid);
    end
    adc_eoc = 1'b1;
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b1) begin
      n_bad++; $display("FAIL stale_eoc_rise: got valid=%b expected 1", rsp_valid);
    end
    adc_eoc = 1'b0;
    tick(); tick();
  endtask

  task automatic test_timeout();
    logic [3:0] g;
    bit ok;
    bit irq_seen;
    apply_reset();
    adc_data = 12'h777; req = 4'b0001;
    run_conv(g);
    tmo_limit = 16'd20; rsp_ready = 1'b0;
    wait_gnt(g, ok);
    req = 4'b0;
`ifdef ADC_ARB_TIMEOUT_EN
    repeat (19) tick();
    n_cmp++;
    if ({rsp_valid, adc_soc} !== 2'b01) begin
      n_bad++; $display("FAIL tmo_early: got valid=%b soc=%b expected 0 1", rsp_valid, adc_soc);
    end
    tick();
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_data, timeout_irq, adc_soc} !== {1'b1, 1'b1, 12'h0, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL tmo_fire: got v=%b err=%b data=%h irq=%b soc=%b expected 1 1 000 1 0",
                        rsp_valid, rsp_err, rsp_data, timeout_irq, adc_soc);
    end
    tick();
    n_cmp++;
    if ({timeout_irq, rsp_valid} !== 2'b01) begin
      n_bad++; $display("FAIL tmo_irq_pulse: got irq=%b valid=%b expected 0 1", timeout_irq, rsp_valid);
    end
    rsp_ready = 1'b1;
    tick();
    tmo_limit = 16'd0; req = 4'b0001;
    wait_gnt(g, ok);
    req = 4'b0;
`endif
    irq_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (timeout_irq) irq_seen = 1'b1;
    end
    n_cmp++;
    if ({rsp_valid, adc_soc, rsp_err, irq_seen} !== 4'b0100) begin
      n_bad++; $display("FAIL tmo_wait_forever: got v=%b soc=%b err=%b irq=%b expected 0 1 0 0",
                        rsp_valid, adc_soc, rsp_err, irq_seen);
    end
    adc_eoc = 1'b1;
    tick();
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 12'h777}) begin
      n_bad++; $display("FAIL tmo_late_eoc: got v=%b err=%b data=%h expected 1 0 777",
                        rsp_valid, rsp_err, rsp_data);
    end
    adc_eoc = 1'b0; rsp_ready = 1'b1;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    logic [3:0] g;
    bit ok;
    apply_reset();
    req = 4'b0100;
    wait_gnt(g, ok);
    req = 4'b0;
    tick();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (all_out !== 29'd0) begin
      n_bad++; $display("FAIL rst_in_conv: got %h expected %h", all_out, 29'd0);
    end
    rst = 1'b0; req = 4'b1111;
    wait_gnt(g, ok);
    n_cmp++;
    if (g !== 4'b0001) begin
      n_bad++; $display("FAIL rst_conv_regrant: got %b expected 0001", g);
    end
    req = 4'b0; rsp_ready = 1'b0;
    tick();
    adc_eoc = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (all_out !== 29'd0) begin
      n_bad++; $display("FAIL rst_in_resp: got %h expected %h", all_out, 29'd0);
    end
    rst = 1'b0; adc_eoc = 1'b0; rsp_ready = 1'b1; req = 4'b1111;
    wait_gnt(g, ok);
    n_cmp++;
    if (g !== 4'b0001) begin
      n_bad++; $display("FAIL rst_resp_regrant: got %b expected 0001", g);
    end
    req = 4'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_gap_stale();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adc_req_arbiter.md
# adc_req_arbiter

Conversion request arbiter sitting between up to four requesters (timer triggers, software, DMA front-end) and the single SAR ADC core. It grants one request at a time (round-robin or fixed priority), drives the core's start-of-conversion and channel select, waits for end-of-conversion, and returns the 12-bit result tagged with requester ID and channel over a valid/ready response port. Optional watchdog aborts conversions that never complete.

## Interface
- NREQ, 4: number of requesters. Fixed at 4; IDs are 2 bits.
- DW, 12: result width.
- TMO_W, 16: timeout counter width.
- GAP_W, 8: inter-conversion gap counter width.

- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  allow new grants
- prio_mode  input  1  0 = round-robin, 1 = fixed (req[0] highest)
- req  input  4  per-requester conversion request (level)
- req_ch  input  12  channel per requester, req_ch[3i+2:3i]
- gnt  output  4  one-hot one-cycle grant pulse
- adc_soc  output  1  start of conversion to ADC core
- adc_ch_sel  output  3  channel select to ADC core
- adc_eoc  input  1  ADC end of conversion (level)
- adc_data  input  DW  ADC conversion result
- gap_cyc  input  GAP_W  minimum soc-low cycles between conversions
- tmo_limit  input  TMO_W  watchdog limit in clk cycles; 0 disables
- rsp_valid  output  1  response available
- rsp_ready  input  1  response accepted
- rsp_id  output  2  granted requester
- rsp_ch  output  3  converted channel
- rsp_data  output  DW  captured result
- rsp_err  output  1  response produced by timeout
- busy  output  1  state != IDLE
- timeout_irq  output  1  one-cycle pulse on timeout

## Operation
- FSM states: IDLE, CONV, RESP, GAP.
- IDLE: if en and |req, pick winner; next cycle -> CONV, gnt[w]=1 for that one cycle, rsp_id/rsp_ch/adc_ch_sel latched from winner. No req or en=0: stay.
- Round-robin: search starts at last_id+1 mod 4; last_id updated on grant. Fixed: lowest asserted index wins. last_id resets to 3 (req[0] first).
- CONV: adc_soc=1 throughout. eoc rise (adc_eoc & ~eoc_q, eoc_q registered) -> capture adc_data into rsp_data, -> RESP.
- RESP: adc_soc=0, rsp_valid=1, outputs stable until rsp_valid & rsp_ready -> GAP.
- GAP: adc_soc=0; count gap_cyc cycles, then -> IDLE. gap_cyc=0: one GAP cycle. Guarantees ADC soc edge detector (sampled on its divided clock) sees soc low.
- req ignored outside IDLE; requester must hold req until gnt and may drop it in the gnt cycle. A req held after gnt is re-arbitrated.
- en deassert mid-operation: current conversion and response complete normally.
- adc_ch_sel held from grant until next grant (not cleared in IDLE).
- prio_mode may change any time; takes effect at next arbitration.

## Timing
- Reset values: gnt=0, adc_soc=0, adc_ch_sel=0, rsp_valid=0, rsp_id=0, rsp_ch=0, rsp_data=0, rsp_err=0, busy=0, timeout_irq=0, state=IDLE, last_id=3, eoc_q=0.
- req seen in IDLE at edge N -> gnt, adc_soc, busy high after edge N (cycle N+1).
- eoc rise sampled at edge M -> rsp_valid high and adc_soc low after edge M.
- Handshake at edge K -> rsp_valid low after K; earliest next gnt at K+gap_cyc+2.
- adc_eoc already high on CONV entry (stale): not a rise; wait for low then rise.
- Reset mid-conversion: all outputs to reset values immediately; pending response discarded.

## Configuration
- ADC_ARB_TIMEOUT_EN defined: counter clears on CONV entry, increments each CONV cycle; when count == tmo_limit (nonzero) -> RESP with rsp_err=1, rsp_data=0, adc_soc=0, timeout_irq one-cycle pulse. An eoc rise in the same cycle wins (normal response, no error).
- Undefined: no counter; CONV waits indefinitely; rsp_err and timeout_irq tied 0; tmo_limit ignored. Ports present in both builds.

## Test plan
- Single req[2], req_ch[8:6]=5, adc_data=0xA5C, gap_cyc=0, rsp_ready=1 -> gnt=4'b0100 one cycle, adc_ch_sel=5, rsp_valid with rsp_id=2, rsp_ch=5, rsp_data=0xA5C, rsp_err=0.
- req=4'b1111 held, prio_mode=0, four conversions -> grant order 0,1,2,3; prio_mode=1 -> order 0,0,0,… while req[0] held.
- rsp_ready low 10 cycles after rsp_valid -> rsp_valid/rsp_data stable 10 cycles, no new gnt, adc_soc low throughout.
- gap_cyc=6, back-to-back req -> adc_soc low ≥ 7 cycles between conversions; adc_eoc stuck high at CONV entry -> no response until low then high.
- ADC_ARB_TIMEOUT_EN, tmo_limit=20, adc_eoc never rises -> after 20 CONV cycles rsp_valid=1, rsp_err=1, rsp_data=0, timeout_irq one pulse; tmo_limit=0 -> waits indefinitely.
- rst asserted during CONV and RESP -> all outputs zero immediately; after release, req[0] granted first.
